sub_div_sequencer: RTL and testbench

//   Multi-cycle 64-bit integer divider controller (RV64M DIV/DIVU/REM/REMU) for the pipelined core.

---
 rtl/sub_div_sequencer_if.sv | 24 ++
 rtl/sub_div_sequencer.sv | 88 ++++++++
 tb/tb_sub_div_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/sub_div_sequencer_if.sv
// sub_div_sequencer_if: divide request/response and external subtractor bus
interface sub_div_sequencer_if #(parameter int WIDTH = 64);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;
  logic [WIDTH-1:0] sub_a;
  logic [WIDTH-1:0] sub_b;
  logic [WIDTH-1:0] sub_diff;
  logic             sub_borrow;
  modport master (
    output start, is_signed, dividend, divisor, sub_diff, sub_borrow,
    input  busy, done, quotient, remainder, div_by_zero, sub_a, sub_b
  );
  modport slave (
    input  start, is_signed, dividend, divisor, sub_diff, sub_borrow,
    output busy, done, quotient, remainder, div_by_zero, sub_a, sub_b
  );
endinterface

// File: rtl/sub_div_sequencer.sv
// sub_div_sequencer: restoring RV64M divider sequencing one external subtractor
module sub_div_sequencer #(
  parameter int WIDTH = 64
) (
  input logic clk,
  input logic rst,
  sub_div_sequencer_if.slave io
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [2:0] {IDLE, NEG_A, NEG_B, ITER, NEG_Q, NEG_R, DONE} state_t;
  state_t state, next;
  logic [WIDTH-1:0] a, b, r, q, shifted;
  logic [CW-1:0] cnt;
  logic neg_a, neg_b, dbz, take;
  assign shifted = {r[WIDTH-2:0], a[WIDTH-1]};
  // r[MSB] is the 65th bit of the partial remainder: when set it always exceeds |B|
  assign take = r[WIDTH-1] | ~io.sub_borrow;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = io.start ? NEG_A : IDLE;
      NEG_A:   next = NEG_B;
      NEG_B:   next = ITER;
      ITER:    next = cnt == '0 ? NEG_Q : ITER;
      NEG_Q:   next = NEG_R;
      NEG_R:   next = DONE;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    io.sub_a = state == ITER ? shifted : '0;
    io.sub_b = state == NEG_A ? a :
               (state == NEG_B || state == ITER) ? b :
               state == NEG_Q ? q :
               state == NEG_R ? r : '0;
    io.busy  = state != IDLE && state != DONE;
    io.done  = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a <= '0;
      b <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      dbz <= 1'b0;
      io.quotient <= '0;
      io.remainder <= '0;
      io.div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (io.start) begin
          a <= io.dividend;
          b <= io.divisor;
          neg_a <= io.is_signed & io.dividend[WIDTH-1];
          neg_b <= io.is_signed & io.divisor[WIDTH-1];
        end
        NEG_A: if (neg_a) a <= io.sub_diff;
        NEG_B: begin
          if (neg_b) b <= io.sub_diff;
          dbz <= b == '0;
          r <= '0;
          q <= '0;
          cnt <= CW'(WIDTH - 1);
        end
        ITER: begin
          a <= a << 1;
          r <= take ? io.sub_diff : shifted;
          q <= {q[WIDTH-2:0], take};
          cnt <= cnt - 1'b1;
        end
        NEG_Q: if ((neg_a ^ neg_b) & ~dbz) q <= io.sub_diff;
        NEG_R: begin
          if (neg_a) r <= io.sub_diff;
          io.quotient <= q;
          io.remainder <= neg_a ? io.sub_diff : r;
          io.div_by_zero <= dbz;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sub_div_sequencer.sv
// tb_sub_div_sequencer: directed RV64M divide vectors against a behavioural subtractor
module tb_sub_div_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  sub_div_sequencer_if #(.WIDTH(64)) dif();
  sub_div_sequencer #(.WIDTH(64)) dut (.clk(clk), .rst(rst), .io(dif));
  always #5 clk = ~clk;
  assign dif.sub_diff   = dif.sub_a - dif.sub_b;
  assign dif.sub_borrow = dif.sub_a < dif.sub_b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drives one accepted request and returns edges from accept to the done cycle (0 if timed out)
  task automatic run(input logic s, input logic [63:0] x, input logic [63:0] y, output int lat);
    dif.start = 1'b1;
    dif.is_signed = s;
    dif.dividend = x;
    dif.divisor = y;
    tick();
    dif.start = 1'b0;
    dif.dividend = 64'h5A5A_5A5A_5A5A_5A5A;
    dif.divisor = 64'h3;
    lat = 0;
    for (int n = 1; n <= 200; n++) begin
      tick();
      if (dif.done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({dif.busy, dif.done, dif.div_by_zero} !== 3'b000 || dif.quotient !== 64'h0 ||
        dif.remainder !== 64'h0 || dif.sub_a !== 64'h0 || dif.sub_b !== 64'h0) begin
      miscompares++;
      $display("FAIL reset: busy=%b done=%b dbz=%b q=%h r=%h sa=%h sb=%h, required all zero",
               dif.busy, dif.done, dif.div_by_zero, dif.quotient, dif.remainder, dif.sub_a, dif.sub_b);
    end
  endtask

  task automatic test_divu();
    int lat;
    run(1'b0, 64'd7, 64'd2, lat);
    vectors++;
    if (lat !== 68) begin miscompares++; $display("FAIL divu_latency: got %0d need 68", lat); end
    vectors++;
    if (dif.quotient !== 64'd3 || dif.remainder !== 64'd1 || dif.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL divu_7_2: q=%h r=%h dbz=%b need 3 1 0", dif.quotient, dif.remainder, dif.div_by_zero);
    end
    vectors++;
    if (dif.busy !== 1'b0) begin miscompares++; $display("FAIL busy_in_done: got %b need 0", dif.busy); end
    tick();
    vectors++;
    if (dif.done !== 1'b0 || dif.quotient !== 64'd3) begin
      miscompares++;
      $display("FAIL done_pulse: done=%b q=%h need 0 and held 3", dif.done, dif.quotient);
    end
    run(1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, lat);
    vectors++;
    if (dif.quotient !== 64'h7FFF_FFFF_FFFF_FFFC || dif.remainder !== 64'd1) begin
      miscompares++;
      $display("FAIL divu_big: q=%h r=%h need 7ffffffffffffffc 1", dif.quotient, dif.remainder);
    end
    tick();
  endtask

  task automatic test_signed();
    int lat;
    run(1'b1, -64'sd7, 64'd2, lat);
    vectors++;
    if (dif.quotient !== 64'hFFFF_FFFF_FFFF_FFFD || dif.remainder !== 64'hFFFF_FFFF_FFFF_FFFF) begin
      miscompares++;
      $display("FAIL div_m7_2: q=%h r=%h need fffffffffffffffd ffffffffffffffff", dif.quotient, dif.remainder);
    end
    tick();
    run(1'b1, 64'd3, -64'sd4, lat);
    vectors++;
    if (dif.quotient !== 64'd0 || dif.remainder !== 64'd3) begin
      miscompares++;
      $display("FAIL div_3_m4: q=%h r=%h need 0 3", dif.quotient, dif.remainder);
    end
    tick();
  endtask

  task automatic test_carry();
    int lat;
    run(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, lat);
    vectors++;
    if (dif.quotient !== 64'd1 || dif.remainder !== 64'h7FFF_FFFF_FFFF_FFFE) begin
      miscompares++;
      $display("FAIL carry_path: q=%h r=%h need 1 7ffffffffffffffe", dif.quotient, dif.remainder);
    end
    tick();
  endtask

  task automatic test_div_zero();
    int lat;
    run(1'b1, -64'sd8, 64'd0, lat);
    vectors++;
    if (dif.quotient !== '1 || dif.remainder !== 64'hFFFF_FFFF_FFFF_FFF8 || dif.div_by_zero !== 1'b1) begin
      miscompares++;
      $display("FAIL div_by_zero: q=%h r=%h dbz=%b need ffffffffffffffff fffffffffffffff8 1",
               dif.quotient, dif.remainder, dif.div_by_zero);
    end
    vectors++;
    if (lat !== 68) begin miscompares++; $display("FAIL dbz_latency: got %0d need 68", lat); end
    tick();
  endtask

  task automatic test_overflow();
    int lat;
    run(1'b1, 64'h8000_0000_0000_0000, '1, lat);
    vectors++;
    if (dif.quotient !== 64'h8000_0000_0000_0000 || dif.remainder !== 64'd0 || dif.div_by_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL overflow: q=%h r=%h dbz=%b need 8000000000000000 0 0",
               dif.quotient, dif.remainder, dif.div_by_zero);
    end
    tick();
  endtask

  task automatic test_start_ignored();
    int lat;
    dif.start = 1'b1;
    dif.is_signed = 1'b0;
    dif.dividend = 64'd100;
    dif.divisor = 64'd7;
    tick();
    dif.start = 1'b0;
    vectors++;
    if (dif.busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_accept: got %b need 1", dif.busy); end
    repeat (9) tick();
    dif.start = 1'b1;
    dif.dividend = 64'd9;
    dif.divisor = 64'd4;
    tick();
    dif.start = 1'b0;
    lat = 0;
    for (int n = 11; n <= 200; n++) begin
      tick();
      if (dif.done) begin
        lat = n;
        break;
      end
    end
    vectors++;
    if (lat !== 68 || dif.quotient !== 64'd14 || dif.remainder !== 64'd2) begin
      miscompares++;
      $display("FAIL start_ignored: lat=%0d q=%h r=%h need 68 e 2", lat, dif.quotient, dif.remainder);
    end
    tick();
  endtask

  task automatic test_rst_abort();
    int seen;
    dif.start = 1'b1;
    dif.is_signed = 1'b0;
    dif.dividend = 64'd50;
    dif.divisor = 64'd5;
    tick();
    dif.start = 1'b0;
    repeat (29) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({dif.busy, dif.done, dif.div_by_zero} !== 3'b000 || dif.quotient !== 64'h0 ||
        dif.remainder !== 64'h0 || dif.sub_a !== 64'h0 || dif.sub_b !== 64'h0) begin
      miscompares++;
      $display("FAIL rst_abort: busy=%b done=%b q=%h r=%h sa=%h sb=%h, required all zero",
               dif.busy, dif.done, dif.quotient, dif.remainder, dif.sub_a, dif.sub_b);
    end
    seen = 0;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (dif.done || dif.busy) seen++;
    end
    vectors++;
    if (seen !== 0) begin miscompares++; $display("FAIL rst_no_done: %0d active cycles, need 0", seen); end
  endtask

  task automatic test_back_to_back();
    int lat;
    run(1'b0, 64'd1000, 64'd33, lat);
    vectors++;
    if (lat !== 68 || dif.quotient !== 64'd30 || dif.remainder !== 64'd10) begin
      miscompares++;
      $display("FAIL after_rst: lat=%0d q=%h r=%h need 68 1e a", lat, dif.quotient, dif.remainder);
    end
    tick();
    run(1'b1, -64'sd1000, -64'sd33, lat);
    vectors++;
    if (lat !== 68 || dif.quotient !== 64'd30 || dif.remainder !== 64'hFFFF_FFFF_FFFF_FFF6) begin
      miscompares++;
      $display("FAIL back_to_back: lat=%0d q=%h r=%h need 68 1e fffffffffffffff6", lat, dif.quotient, dif.remainder);
    end
  endtask

  initial begin
    dif.start = 1'b0;
    dif.is_signed = 1'b0;
    dif.dividend = '0;
    dif.divisor = '0;
    test_reset();
    test_divu();
    test_signed();
    test_carry();
    test_div_zero();
    test_overflow();
    test_start_ignored();
    test_rst_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
